pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It keeps a scoreboard of in-flight destination registers from EX through WB, and from it generates load-use stalls, bubble insertion, branch-redirect flushes and per-operand forwarding selects. It sits beside the decode stage and drives the IF/ID/EX pipeline-register enables and the EX operand muxes. It also keeps saturating stall and flush event counters for performance analysis.

---
 rtl/pipeline_hazard_unit.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard and forwarding controller for a five-stage MIPS pipeline. A small
//   scoreboard tracks the destination of every instruction from EX through WB.
//   The unit uses it to produce load-use stalls, ID/EX bubbles, branch-redirect
//   flushes and the EX operand forwarding selects. Two saturating counters
//   record hazard-stall cycles and accepted redirects.
//
// Ports
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_id_*                  decode-stage instruction fields
//   i_ex_redirect           taken branch/jump resolved in EX
//   i_stall_ext             external freeze (memory wait)
//   o_stall/o_bubble/o_flush  pipeline register controls
//   o_fwd_rs_sel/o_fwd_rt_sel 0 = register file, k+1 = forward from stage k
//   o_stall_count/o_flush_count saturating performance counters
module pipeline_hazard_unit #(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_id_dest,
    input  logic                  i_id_writes,
    input  logic                  i_id_is_load,
    input  logic                  i_ex_redirect,
    input  logic                  i_stall_ext,
    output logic                  o_stall,
    output logic                  o_bubble,
    output logic                  o_flush,
    output logic [SEL_W-1:0]      o_fwd_rs_sel,
    output logic [SEL_W-1:0]      o_fwd_rt_sel,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);

    // Scoreboard: index 0 = EX, NUM_STAGES-1 = WB.
    logic [NUM_STAGES-1:0] r_vld;
    logic [NUM_STAGES-1:0] r_wr;
    logic [NUM_STAGES-1:0] r_ld;
    logic [REG_ADDR_W-1:0] r_dest [NUM_STAGES];
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic [NUM_STAGES-1:0] w_rs_hit;
    logic [NUM_STAGES-1:0] w_rt_hit;
    logic [NUM_STAGES-1:0] w_rs_fwd;
    logic [NUM_STAGES-1:0] w_rt_fwd;
    logic [NUM_STAGES-1:0] w_early;
    logic [SEL_W-1:0]      w_rs_sel;
    logic [SEL_W-1:0]      w_rt_sel;
    logic                  w_hazard;
    logic                  w_kill;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_rs_hit = '0;
        w_rt_hit = '0;
        w_rs_fwd = '0;
        w_rt_fwd = '0;
        w_early  = '0;
        w_rs_sel = '0;
        w_rt_sel = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            // Stages below LOAD_READY do not yet hold load data.
            w_early[k]  = (k < LOAD_READY);
            w_rs_hit[k] = r_vld[k] && r_wr[k] && i_id_uses_rs &&
                          (i_id_rs != '0) && (r_dest[k] == i_id_rs);
            w_rt_hit[k] = r_vld[k] && r_wr[k] && i_id_uses_rt &&
                          (i_id_rt != '0) && (r_dest[k] == i_id_rt);
            w_rs_fwd[k] = w_rs_hit[k] && !(r_ld[k] && w_early[k]);
            w_rt_fwd[k] = w_rt_hit[k] && !(r_ld[k] && w_early[k]);
        end
        // Scan oldest to youngest so the youngest forwardable producer wins.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (w_rs_fwd[k]) w_rs_sel = SEL_W'(k + 1);
            if (w_rt_fwd[k]) w_rt_sel = SEL_W'(k + 1);
        end
        w_hazard = |((w_rs_hit | w_rt_hit) & r_ld & w_early);
    end

    // A redirect discards any concurrent hazard; either one injects a bubble.
    assign w_kill        = i_ex_redirect | w_hazard;
    assign o_stall       = i_stall_ext | (!i_ex_redirect && w_hazard);
    assign o_bubble      = !i_stall_ext && w_kill;
    assign o_flush       = !i_stall_ext && i_ex_redirect;
    assign o_fwd_rs_sel  = w_rs_sel;
    assign o_fwd_rt_sel  = w_rt_sel;
    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld       <= '0;
            r_wr        <= '0;
            r_ld        <= '0;
            for (int k = 0; k < NUM_STAGES; k++) r_dest[k] <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!i_stall_ext) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_wr[k]   <= r_wr[k-1];
                r_ld[k]   <= r_ld[k-1];
                r_dest[k] <= r_dest[k-1];
            end
            r_vld[0]  <= i_id_valid && !w_kill;
            r_wr[0]   <= i_id_writes && !w_kill;
            r_ld[0]   <= i_id_is_load && !w_kill;
            r_dest[0] <= w_kill ? '0 : i_id_dest;
            if (i_ex_redirect)
                r_flush_cnt <= sat_inc(r_flush_cnt);
            else if (w_hazard)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit. Two instances share one stimulus
// stream: A (3 stages, load ready at 1, 4-bit counters) and
// B (5 stages, load ready at 3, 16-bit counters). A queue-based model of the
// in-flight instructions provides every expected value.
module tb_pipeline_hazard_unit;

    typedef struct packed {
        bit       v;
        bit [4:0] d;
        bit       w;
        bit       l;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       idv = 1'b0;
    logic [4:0] rs = '0, rt = '0, dest = '0;
    logic       urs = 1'b0, urt = 1'b0, wr = 1'b0, ld = 1'b0;
    logic       redir = 1'b0, ext = 1'b0;

    logic        a_stall, a_bubble, a_flush;
    logic [1:0]  a_rs, a_rt;
    logic [3:0]  a_sc, a_fc;
    logic        b_stall, b_bubble, b_flush;
    logic [2:0]  b_rs, b_rt;
    logic [15:0] b_sc, b_fc;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t mq [2][$];
    int   m_sc [2];
    int   m_fc [2];

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.NUM_STAGES(3), .REG_ADDR_W(5), .LOAD_READY(1), .CNT_W(4)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_id_valid(idv), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_uses_rs(urs), .i_id_uses_rt(urt), .i_id_dest(dest), .i_id_writes(wr),
        .i_id_is_load(ld), .i_ex_redirect(redir), .i_stall_ext(ext),
        .o_stall(a_stall), .o_bubble(a_bubble), .o_flush(a_flush),
        .o_fwd_rs_sel(a_rs), .o_fwd_rt_sel(a_rt),
        .o_stall_count(a_sc), .o_flush_count(a_fc)
    );

    pipeline_hazard_unit #(.NUM_STAGES(5), .REG_ADDR_W(5), .LOAD_READY(3), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_id_valid(idv), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_uses_rs(urs), .i_id_uses_rt(urt), .i_id_dest(dest), .i_id_writes(wr),
        .i_id_is_load(ld), .i_ex_redirect(redir), .i_stall_ext(ext),
        .o_stall(b_stall), .o_bubble(b_bubble), .o_flush(b_flush),
        .o_fwd_rs_sel(b_rs), .o_fwd_rt_sel(b_rt),
        .o_stall_count(b_sc), .o_flush_count(b_fc)
    );

    function automatic int ns_of(int i);
        return (i == 0) ? 3 : 5;
    endfunction

    function automatic int lr_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    // q[0] is the youngest in-flight instruction (the one now in EX).
    function automatic int ref_sel(ent_t q[$], bit [4:0] r, bit used, int lr);
        if (!used || r == 0) return 0;
        for (int k = 0; k < q.size(); k++)
            if (q[k].v && q[k].w && q[k].d == r && (k >= lr || !q[k].l)) return k + 1;
        return 0;
    endfunction

    function automatic bit ref_haz(ent_t q[$], bit [4:0] s, bit us, bit [4:0] t, bit ut, int lr);
        for (int k = 0; k < q.size() && k < lr; k++)
            if (q[k].v && q[k].w && q[k].l &&
                ((us && s != 0 && q[k].d == s) || (ut && t != 0 && q[k].d == t)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input int i, input logic [31:0] es, eb, ef, ers, ert, esc, efc);
        string p;
        p = (i == 0) ? "a" : "b";
        check({p, ".stall"},  32'(i == 0 ? a_stall  : b_stall),  es);
        check({p, ".bubble"}, 32'(i == 0 ? a_bubble : b_bubble), eb);
        check({p, ".flush"},  32'(i == 0 ? a_flush  : b_flush),  ef);
        check({p, ".fwd_rs"}, (i == 0) ? 32'(a_rs) : 32'(b_rs),  ers);
        check({p, ".fwd_rt"}, (i == 0) ? 32'(a_rt) : 32'(b_rt),  ert);
        check({p, ".scnt"},   (i == 0) ? 32'(a_sc) : 32'(b_sc),  esc);
        check({p, ".fcnt"},   (i == 0) ? 32'(a_fc) : 32'(b_fc),  efc);
    endtask

    // Drive one ID-stage cycle at the falling edge and check against the model.
    task automatic apply(input bit v, input bit [4:0] s, input bit us, input bit [4:0] t,
                         input bit ut, input bit [4:0] d, input bit w, input bit l,
                         input bit rd, input bit x);
        @(negedge clk);
        idv = v; rs = s; urs = us; rt = t; urt = ut; dest = d; wr = w; ld = l;
        redir = rd; ext = x;
        #1;
        for (int i = 0; i < 2; i++) begin
            bit hz;
            hz = ref_haz(mq[i], rs, urs, rt, urt, lr_of(i));
            check_outputs(i, 32'(ext | (!redir && hz)), 32'(!ext && (redir | hz)),
                          32'(!ext && redir),
                          ref_sel(mq[i], rs, urs, lr_of(i)), ref_sel(mq[i], rt, urt, lr_of(i)),
                          m_sc[i], m_fc[i]);
        end
    endtask

    // Advance the model by one rising edge.
    task automatic commit();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit   hz;
            ent_t e;
            hz = ref_haz(mq[i], rs, urs, rt, urt, lr_of(i));
            if (!ext) begin
                e = '0;
                if (!redir && !hz) begin
                    e.v = idv; e.d = dest; e.w = wr; e.l = ld;
                end
                mq[i].push_front(e);
                if (mq[i].size() > ns_of(i)) void'(mq[i].pop_back());
                if (redir) begin
                    if (m_fc[i] < cmax_of(i)) m_fc[i]++;
                end else if (hz) begin
                    if (m_sc[i] < cmax_of(i)) m_sc[i]++;
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input bit [4:0] s, input bit us, input bit [4:0] t,
                       input bit ut, input bit [4:0] d, input bit w, input bit l,
                       input bit rd, input bit x);
        apply(v, s, us, t, ut, d, w, l, rd, x);
        commit();
    endtask

    task automatic idle_inputs();
        idv = 0; rs = 0; rt = 0; urs = 0; urt = 0; dest = 0; wr = 0; ld = 0;
        redir = 0; ext = 0;
    endtask

    // Assert reset between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_sc[i] = 0;
            m_fc[i] = 0;
            check_outputs(i, 0, 0, 0, 0, 0, 0, 0);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        // Reset with no clock edge yet, then release.
        do_reset();

        // ALU chain: add $3 ; add $4,$3
        cyc(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
        apply(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0);
        check("alu.a_fwd_rs", 32'(a_rs), 1);
        check("alu.a_stall", 32'(a_stall), 0);
        commit();

        // lw $5 ; add $6,$5,$0 held in ID
        idle_inputs(); do_reset();
        cyc(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        apply(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0);
        check("lu.a_stall1", 32'(a_stall), 1);
        check("lu.a_bubble1", 32'(a_bubble), 1);
        commit();
        apply(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0);
        check("lu.a_stall2", 32'(a_stall), 0);
        check("lu.a_fwd_rs", 32'(a_rs), 2);
        check("lu.a_scnt", 32'(a_sc), 1);
        check("lu.b_stall2", 32'(b_stall), 1);
        commit();
        apply(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0);
        check("lu.b_stall3", 32'(b_stall), 1);
        commit();
        apply(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0);
        check("lu.b_stall4", 32'(b_stall), 0);
        check("lu.b_fwd_rs", 32'(b_rs), 4);
        check("lu.b_scnt", 32'(b_sc), 3);
        commit();

        // Writes (including a load) to $0 never create dependences.
        idle_inputs(); do_reset();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
        apply(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0);
        check("r0.a_fwd_rs", 32'(a_rs), 0);
        check("r0.a_fwd_rt", 32'(a_rt), 0);
        check("r0.a_stall", 32'(a_stall), 0);
        commit();

        // $7 in stage 0 and stage 2: youngest wins.
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
        apply(1, 5'd1, 0, 5'd7, 1, 5'd2, 1, 0, 0, 0);
        check("young.a_fwd_rt", 32'(a_rt), 1);
        check("young.b_fwd_rt", 32'(b_rt), 1);
        commit();

        // Redirect together with a load-use hazard.
        idle_inputs(); do_reset();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        apply(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0);
        check("rdh.a_flush", 32'(a_flush), 1);
        check("rdh.a_stall", 32'(a_stall), 0);
        commit();
        #1;
        check("rdh.a_fcnt", 32'(a_fc), 1);
        check("rdh.a_scnt", 32'(a_sc), 0);

        // Redirect during an external freeze: ignored, scoreboard held.
        idle_inputs(); do_reset();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        apply(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        check("rdx.a_flush", 32'(a_flush), 0);
        check("rdx.a_stall", 32'(a_stall), 1);
        check("rdx.a_bubble", 32'(a_bubble), 0);
        commit();
        apply(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
        check("rdx.a_held_haz", 32'(a_stall), 1);
        check("rdx.a_fcnt", 32'(a_fc), 0);
        commit();

        // Saturation of the 4-bit stall counter.
        idle_inputs(); do_reset();
        for (int n = 0; n < 20; n++) begin
            cyc(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
            cyc(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
        end
        #1;
        check("sat.a_scnt", 32'(a_sc), 15);

        // Random traffic over a small register set to provoke dependences.
        idle_inputs(); do_reset();
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 7) != 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset in the middle of a load-use stall.
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        apply(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0);
        check("mid.b_stall_pre", 32'(b_stall), 1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
